// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage. Owns HI/LO, runs one
// shift-add or restoring shift-subtract step per cycle, then sign-corrects.
`timescale 1ns/1ps
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mf_req,
    input  logic             abort,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // a: product upper half / partial remainder; q: multiplier / quotient; b: mcand / divisor
    logic [WIDTH-1:0]     a_q, a_d, q_q, q_d, b_q, b_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum, div_shift;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_mag, prod_fix;

    // Operand magnitudes and datapath step results
    always_comb begin
        is_signed = ~op[0];
        rs_neg    = is_signed & rs_data[WIDTH-1];
        rt_neg    = is_signed & rt_data[WIDTH-1];
        rs_mag    = rs_neg ? -rs_data : rs_data;
        rt_mag    = rt_neg ? -rt_data : rt_data;
        mul_sum   = {1'b0, a_q} + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {a_q, q_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        prod_mag  = {a_q, q_q};
        prod_fix  = neg_lo_q ? -prod_mag : prod_mag;
    end

    // Next-state, datapath and result write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    a_d      = '0;
                    is_div_d = op[1];
                    neg_lo_d = rs_neg ^ rt_neg;
                    if (op[1]) begin
                        q_d      = rs_mag;
                        b_d      = rt_mag;
                        neg_hi_d = rs_neg;
                        div0_d   = (rt_data == '0);
                    end else begin
                        q_d      = rt_mag;
                        b_d      = rs_mag;
                        neg_hi_d = 1'b0;
                        div0_d   = 1'b0;
                    end
                end
            end
            StCalc: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    if (is_div_q) begin
                        // Remainder always fits WIDTH bits, so the subtraction can drop the top bit
                        a_d = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
                        q_d = {q_q[WIDTH-2:0], div_ge};
                    end else begin
                        a_d = mul_sum[WIDTH:1];
                        q_d = {mul_sum[0], q_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Divide by zero: quotient forced to ones; remainder already equals rs_data
                        lo_d = div0_q ? '1 : (neg_lo_q ? -q_q : q_q);
                        hi_d = neg_hi_q ? -a_q : a_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            q_q      <= q_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // Outputs; stall only when a dependent instruction is waiting on the unit
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = (state_q != StIdle);
        done  = done_q;
        stall = busy & (start | mf_req);
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the MIPS pipeline.
- Executes MULT, MULTU, DIV and DIVU, and owns the architectural HI/LO registers.
- Drives a stall signal that the hazard logic routes to the enable inputs of the upstream IF/ID and ID/EX pipeline registers.
- Feeds HI/LO values to the EX/MEM pipeline register for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage instruction is MULT/MULTU/DIV/DIVU. Request to begin.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  multiplicand / dividend.
- rt_data  input  WIDTH  multiplier / divisor.
- mf_req  input  1  EX-stage instruction is MFHI/MFLO.
- abort  input  1  flush from branch/exception logic. Cancels the in-flight operation.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: HI/LO have just been updated.
- stall  output  1  hold upstream pipeline registers.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; hi=0, lo=0; busy=0, done=0; internal counter and accumulators cleared. Reset asserted mid-operation discards the operation.
- FSM states:
  - IDLE -> CALC when start=1 and abort=0. This edge latches op and the operand magnitudes (absolute values for MULT/DIV) and records the result signs.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Counter runs 0..WIDTH-1. On the last step, go to FIX.
  - FIX: apply sign correction, write hi/lo, go to IDLE.
- Latency: start sampled at edge E0. hi/lo change at edge E0+WIDTH+1 (33 cycles for WIDTH=32). busy=1 for the WIDTH+1 cycles following E0. done=1 for exactly the one cycle after that edge.
- busy is registered: high in CALC and FIX, low otherwise.
- stall is combinational: stall = busy & (start | mf_req). Independent instructions proceed while the unit iterates.
- start while busy: ignored; upstream holds the instruction via stall. It is accepted on the first IDLE cycle.
- abort while busy: next edge goes to IDLE, busy=0, hi/lo unchanged, no done pulse.
- abort and start in the same IDLE cycle: abort wins; nothing starts.
- abort has priority over the FIX write.
- Signed multiply: the 2*WIDTH-bit two's-complement product is split {hi,lo}.
- Signed division:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0.
- Divide by zero, both DIV and DIVU: hi=rs_data, lo=all ones. Latency is unchanged and no exception is raised.
- hi/lo hold their value in all other cycles. MFHI/MFLO read hi/lo directly once stall is released.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 exactly 33 cycles after start; done pulses once; busy high for 33 cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 7 / 0 -> hi=7, lo=0xFFFFFFFF after 33 cycles.
- Hazard stall, phase 1: start MULTU, then mf_req=1 at cycle 5 -> stall=1 until busy falls.
- Hazard stall, phase 2: mf_req=0 with an independent instruction -> stall=0.
- Hazard stall, phase 3: a second start while busy -> stall=1, then accepted on the first IDLE cycle.
- Abort at cycle 10 of a DIV -> busy=0 on the next cycle, no done, hi/lo keep their prior values.
- Reset pulse low at cycle 20 of an operation -> hi=lo=0, busy=0 immediately, without waiting for clk.
